// File: rtl/csr_pkg.sv
// Shared encodings for the Zicsr access unit.
// Holds funct3 opcodes, CSR addresses and the FSM state type.
package csr_pkg;

   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;

   localparam logic [11:0] CSR_FFLAGS   = 12'h001;
   localparam logic [11:0] CSR_FRM      = 12'h002;
   localparam logic [11:0] CSR_FCSR     = 12'h003;
   localparam logic [11:0] CSR_CYCLE    = 12'hC00;
   localparam logic [11:0] CSR_INSTRET  = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH = 12'hC82;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/csr_op_alu.sv
// Read-modify-write datapath for CSR instructions.
// RS/RC with a zero rs1 field carry no write intent.
module csr_op_alu
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      op,
   input  logic [4:0]      rs1_idx,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] src,
   output logic [XLEN-1:0] new_val,
   output logic            write_intent
);

   logic nz_idx;
   assign nz_idx = |rs1_idx;

   always_comb begin
      new_val      = '0;
      write_intent = 1'b0;
      unique case (op)
         2'b01: begin
            new_val      = src;
            write_intent = 1'b1;
         end
         2'b10: begin
            new_val      = old_val | src;
            write_intent = nz_idx;
         end
         2'b11: begin
            new_val      = old_val & ~src;
            write_intent = nz_idx;
         end
         default: begin
            new_val      = '0;
            write_intent = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one Zicsr instruction at a time: read, modify, write, respond.
// Illegal requests keep the same timing but never strobe the regfile.
module csr_access_unit
   import csr_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit RO_CHECK = 1'b1
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      req_funct3_i,
   input  logic [11:0]     req_addr_i,
   input  logic [4:0]      req_rs1Idx_i,
   input  logic [XLEN-1:0] req_rs1Data_i,
   input  logic            flush_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] resp_rdData_o,
   output logic            resp_illegal_o,
   output logic [11:0]     csrRAddr_o,
   input  logic [XLEN-1:0] csrRData_i,
   output logic [11:0]     csrWAddr_o,
   output logic [XLEN-1:0] csrWData_o,
   output logic            csrWEn_o
);

   state_t state, state_n;

   logic [2:0]      f3_q;
   logic [11:0]     addr_q;
   logic [4:0]      idx_q;
   logic [XLEN-1:0] data_q;
   logic [XLEN-1:0] old_q;

   logic            accept;
   logic [XLEN-1:0] src;
   logic [XLEN-1:0] new_val;
   logic            write_intent;
   logic            mapped;
   logic            read_only;
   logic            ro_chk;
   logic            illegal;
   logic            do_write;

   assign accept = req_valid_i & (state == S_IDLE) & ~flush_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state <= S_IDLE;
      else         state <= state_n;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         f3_q   <= '0;
         addr_q <= '0;
         idx_q  <= '0;
         data_q <= '0;
         old_q  <= '0;
      end else begin
         if (accept) begin
            f3_q   <= req_funct3_i;
            addr_q <= req_addr_i;
            idx_q  <= req_rs1Idx_i;
            data_q <= req_rs1Data_i;
         end
         if (state == S_READ) old_q <= csrRData_i;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (accept) state_n = S_READ;
         S_READ:  state_n = flush_i ? S_IDLE : S_WRITE;
         S_WRITE: state_n = S_RESP;
         S_RESP:  if (resp_ready_i) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign src = f3_q[2] ? {{(XLEN-5){1'b0}}, idx_q} : data_q;

   csr_op_alu #(.XLEN(XLEN)) u_alu (
      .op           (f3_q[1:0]),
      .rs1_idx      (idx_q),
      .old_val      (old_q),
      .src          (src),
      .new_val      (new_val),
      .write_intent (write_intent)
   );

   always_comb begin
      mapped = 1'b0;
      case (addr_q)
         CSR_FFLAGS, CSR_FRM, CSR_FCSR,
         CSR_CYCLE, CSR_INSTRET,
         CSR_CYCLEH, CSR_INSTRETH: mapped = 1'b1;
         default:                  mapped = 1'b0;
      endcase
   end

   assign ro_chk    = RO_CHECK;
   assign read_only = (addr_q[11:10] == 2'b11);
   assign illegal   = ~mapped
                    | (f3_q[1:0] == 2'b00)
                    | (write_intent & read_only & ro_chk);
   // Without RO checking a read-only write is dropped, not flagged.
   assign do_write  = write_intent & ~illegal
                    & ~(read_only & ~ro_chk);

   always_comb begin
      req_ready_o    = (state == S_IDLE);
      resp_valid_o   = 1'b0;
      resp_rdData_o  = '0;
      resp_illegal_o = 1'b0;
      csrRAddr_o     = '0;
      csrWAddr_o     = '0;
      csrWData_o     = '0;
      csrWEn_o       = 1'b0;
      unique case (state)
         S_READ:  csrRAddr_o = addr_q;
         S_WRITE: begin
            csrWEn_o   = do_write;
            csrWAddr_o = do_write ? addr_q : 12'h000;
            csrWData_o = new_val;
         end
         S_RESP: begin
            resp_valid_o   = 1'b1;
            resp_illegal_o = illegal;
            resp_rdData_o  = illegal ? '0 : old_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit with RO_CHECK=1 and RO_CHECK=0.
// Both instances see identical stimulus; expectations are queued per instance.
module tb_csr_access_unit;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        req_valid_i;
   logic [2:0]  req_funct3_i;
   logic [11:0] req_addr_i;
   logic [4:0]  req_rs1Idx_i;
   logic [31:0] req_rs1Data_i;
   logic        flush_i;
   logic        resp_ready_i;
   logic        tb_init;

   logic        ready_a, rv_a, ill_a, wen_a;
   logic [31:0] rd_a, rdat_a, wdata_a;
   logic [11:0] raddr_a, waddr_a;
   logic        ready_b, rv_b, ill_b, wen_b;
   logic [31:0] rd_b, rdat_b, wdata_b;
   logic [11:0] raddr_b, waddr_b;

   logic [31:0] rf_a [4096];
   logic [31:0] rf_b [4096];

   typedef struct {
      logic [31:0] rd;
      logic        ill;
   } rsp_t;
   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   rsp_t rq_a[$], rq_b[$];
   wr_t  wq_a[$], wq_b[$];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   csr_access_unit #(.XLEN(32), .RO_CHECK(1'b1)) dut_a (
      .clk_i(clk_i), .reset_i(reset_i),
      .req_valid_i(req_valid_i), .req_ready_o(ready_a),
      .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i),
      .req_rs1Idx_i(req_rs1Idx_i), .req_rs1Data_i(req_rs1Data_i),
      .flush_i(flush_i), .resp_valid_o(rv_a),
      .resp_ready_i(resp_ready_i), .resp_rdData_o(rd_a),
      .resp_illegal_o(ill_a), .csrRAddr_o(raddr_a),
      .csrRData_i(rdat_a), .csrWAddr_o(waddr_a),
      .csrWData_o(wdata_a), .csrWEn_o(wen_a)
   );

   csr_access_unit #(.XLEN(32), .RO_CHECK(1'b0)) dut_b (
      .clk_i(clk_i), .reset_i(reset_i),
      .req_valid_i(req_valid_i), .req_ready_o(ready_b),
      .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i),
      .req_rs1Idx_i(req_rs1Idx_i), .req_rs1Data_i(req_rs1Data_i),
      .flush_i(flush_i), .resp_valid_o(rv_b),
      .resp_ready_i(resp_ready_i), .resp_rdData_o(rd_b),
      .resp_illegal_o(ill_b), .csrRAddr_o(raddr_b),
      .csrRData_i(rdat_b), .csrWAddr_o(waddr_b),
      .csrWData_o(wdata_b), .csrWEn_o(wen_b)
   );

   function automatic logic [31:0] defv(input logic [11:0] a);
      case (a)
         12'h001: defv = 32'h0000_001F;
         12'h002: defv = 32'h0000_0005;
         12'h003: defv = 32'h0000_0000;
         12'hC00: defv = 32'h0000_1234;
         12'hC02: defv = 32'h0000_ABCD;
         12'hC80: defv = 32'h0000_0007;
         12'hC82: defv = 32'h0000_0009;
         default: defv = 32'hFFFF_FFFF;
      endcase
   endfunction

   always @(posedge clk_i) begin
      if (tb_init) begin
         for (int i = 0; i < 4096; i++) begin
            rf_a[i] <= defv(i[11:0]);
            rf_b[i] <= defv(i[11:0]);
         end
      end else begin
         if (wen_a) rf_a[waddr_a] <= wdata_a;
         if (wen_b) rf_b[waddr_b] <= wdata_b;
      end
   end

   assign rdat_a = rf_a[raddr_a];
   assign rdat_b = rf_b[raddr_b];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected or missing event", nm);
   endtask

   always @(negedge clk_i) begin
      rsp_t r;
      wr_t  w;
      if (rv_a && resp_ready_i) begin
         if (rq_a.size() == 0) bad("resp_a");
         else begin
            r = rq_a.pop_front();
            chk("rd_a", rd_a, r.rd);
            chk("ill_a", {31'b0, ill_a}, {31'b0, r.ill});
         end
      end
      if (rv_b && resp_ready_i) begin
         if (rq_b.size() == 0) bad("resp_b");
         else begin
            r = rq_b.pop_front();
            chk("rd_b", rd_b, r.rd);
            chk("ill_b", {31'b0, ill_b}, {31'b0, r.ill});
         end
      end
      if (wen_a) begin
         if (wq_a.size() == 0) bad("wen_a");
         else begin
            w = wq_a.pop_front();
            chk("waddr_a", {20'b0, waddr_a}, {20'b0, w.addr});
            chk("wdata_a", wdata_a, w.data);
         end
      end
      if (wen_b) begin
         if (wq_b.size() == 0) bad("wen_b");
         else begin
            w = wq_b.pop_front();
            chk("waddr_b", {20'b0, waddr_b}, {20'b0, w.addr});
            chk("wdata_b", wdata_b, w.data);
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!ready_a && n < 40) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      if (n >= 40) bad("ready_timeout");
   endtask

   task automatic pulse(input logic [2:0] f3, input logic [11:0] a,
                        input logic [4:0] idx, input logic [31:0] d);
      req_funct3_i  = f3;
      req_addr_i    = a;
      req_rs1Idx_i  = idx;
      req_rs1Data_i = d;
      req_valid_i   = 1'b1;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
   endtask

   task automatic vec(input logic [2:0] f3, input logic [11:0] a,
                      input logic [4:0] idx, input logic [31:0] d,
                      input logic [31:0] ra, input logic ia,
                      input logic [31:0] rb, input logic ib,
                      input logic we, input logic [31:0] wd);
      wait_ready();
      rq_a.push_back('{rd: ra, ill: ia});
      rq_b.push_back('{rd: rb, ill: ib});
      if (we) begin
         wq_a.push_back('{addr: a, data: wd});
         wq_b.push_back('{addr: a, data: wd});
      end
      pulse(f3, a, idx, d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset_i       = 1'b1;
      tb_init       = 1'b1;
      req_valid_i   = 1'b0;
      req_funct3_i  = 3'b0;
      req_addr_i    = 12'h0;
      req_rs1Idx_i  = 5'h0;
      req_rs1Data_i = 32'h0;
      flush_i       = 1'b0;
      resp_ready_i  = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      tb_init = 1'b0;
      reset_i = 1'b0;
      @(negedge clk_i);
      chk("rst_ready", {31'b0, ready_a}, 32'd1);
      chk("rst_ready_b", {31'b0, ready_b}, 32'd1);
      chk("rst_rvalid", {31'b0, rv_a}, 32'd0);
      chk("rst_ill", {31'b0, ill_a}, 32'd0);
      chk("rst_wen", {31'b0, wen_a}, 32'd0);
      chk("rst_waddr", {20'b0, waddr_a}, 32'd0);
      chk("rst_wdata", wdata_a, 32'd0);
      chk("rst_rd", rd_a, 32'd0);
      chk("rst_raddr", {20'b0, raddr_a}, 32'd0);
      @(posedge clk_i);
      #1;

      //  f3      addr     idx    data           rd_a  il rd_b  il we wdata
      vec(3'b001, 12'h003, 5'd1,  32'h0000_00A5, 32'h0, 0, 32'h0, 0, 1, 32'hA5);
      vec(3'b010, 12'h002, 5'd0,  32'h0000_FFFF, 32'h5, 0, 32'h5, 0, 0, 32'h0);
      vec(3'b001, 12'hC00, 5'd1,  32'h0000_0077, 32'h0, 1, 32'h1234, 0, 0, 32'h0);
      vec(3'b111, 12'h001, 5'h03, 32'h0,         32'h1F, 0, 32'h1F, 0, 1, 32'h1C);
      vec(3'b001, 12'h7C0, 5'd1,  32'h1,         32'h0, 1, 32'h0, 1, 0, 32'h0);
      vec(3'b010, 12'h001, 5'd4,  32'h0000_0100, 32'h1C, 0, 32'h1C, 0, 1, 32'h11C);
      vec(3'b110, 12'hC02, 5'd1,  32'h0,         32'h0, 1, 32'hABCD, 0, 0, 32'h0);
      vec(3'b011, 12'hC80, 5'd0,  32'hFF,        32'h7, 0, 32'h7, 0, 0, 32'h0);
      vec(3'b100, 12'h003, 5'd2,  32'h0,         32'h0, 1, 32'h0, 1, 0, 32'h0);
      vec(3'b101, 12'h002, 5'h1F, 32'h0,         32'h5, 0, 32'h5, 0, 1, 32'h1F);
      vec(3'b000, 12'h001, 5'd1,  32'h1,         32'h0, 1, 32'h0, 1, 0, 32'h0);
      vec(3'b011, 12'h003, 5'd5,  32'h21,        32'hA5, 0, 32'hA5, 0, 1, 32'h84);
      vec(3'b001, 12'h004, 5'd1,  32'h1,         32'h0, 1, 32'h0, 1, 0, 32'h0);
      vec(3'b001, 12'hC82, 5'd0,  32'h0,         32'h0, 1, 32'h9, 0, 0, 32'h0);
      vec(3'b001, 12'h002, 5'd0,  32'h0,         32'h1F, 0, 32'h1F, 0, 1, 32'h0);

      // flush while in READ: request vanishes
      wait_ready();
      pulse(3'b001, 12'h003, 5'd1, 32'hEE);
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      @(negedge clk_i);
      chk("flush_ready", {31'b0, ready_a}, 32'd1);
      chk("flush_rvalid", {31'b0, rv_a}, 32'd0);
      @(posedge clk_i);
      #1;

      // flush in IDLE blocks acceptance
      req_valid_i = 1'b1;
      flush_i     = 1'b1;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      flush_i     = 1'b0;
      @(negedge clk_i);
      chk("idle_flush_ready", {31'b0, ready_a}, 32'd1);
      @(posedge clk_i);
      #1;

      // response back-pressure for 3 cycles
      resp_ready_i = 1'b0;
      vec(3'b001, 12'h001, 5'd1, 32'hDEAD_0000, 32'h11C, 0, 32'h11C, 0,
          1, 32'hDEAD_0000);
      req_valid_i = 1'b1;
      req_addr_i  = 12'h002;
      n = 0;
      @(negedge clk_i);
      while (!rv_a && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 10) bad("resp_timeout");
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk_i);
         chk("stall_rvalid", {31'b0, rv_a}, 32'd1);
         chk("stall_rd", rd_a, 32'h11C);
         chk("stall_ready", {31'b0, ready_a}, 32'd0);
      end
      @(posedge clk_i);
      #1;
      req_valid_i  = 1'b0;
      resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;

      // async reset during WRITE aborts the strobe
      wait_ready();
      pulse(3'b001, 12'h003, 5'd1, 32'h55);
      @(posedge clk_i);
      #2;
      chk("pre_rst_wen", {31'b0, wen_a}, 32'd1);
      chk("pre_rst_waddr", {20'b0, waddr_a}, 32'h003);
      chk("pre_rst_wdata", wdata_a, 32'h55);
      #1;
      reset_i = 1'b1;
      #1;
      chk("rst_mid_wen", {31'b0, wen_a}, 32'd0);
      chk("rst_mid_wen_b", {31'b0, wen_b}, 32'd0);
      chk("rst_mid_ready", {31'b0, ready_a}, 32'd1);
      chk("rst_mid_waddr", {20'b0, waddr_a}, 32'd0);
      reset_i = 1'b0;
      @(posedge clk_i);
      #1;

      vec(3'b010, 12'h003, 5'd0, 32'h0, 32'h84, 0, 32'h84, 0, 0, 32'h0);
      vec(3'b010, 12'h001, 5'd0, 32'h0, 32'hDEAD_0000, 0,
          32'hDEAD_0000, 0, 0, 32'h0);

      n = 0;
      while ((rq_a.size() != 0 || !ready_a) && n < 40) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      chk("rq_a_empty", rq_a.size(), 32'd0);
      chk("rq_b_empty", rq_b.size(), 32'd0);
      chk("wq_a_empty", wq_a.size(), 32'd0);
      chk("wq_b_empty", wq_b.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
